// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding command-stream to AXI-Lite initiator.
// Each accepted command becomes one AXI-Lite write (AW+W, then B) or read
// (AR, then R); the captured outcome is returned as one response beat.
// All AXI-Lite outputs come straight from registers.
module axil_cmd_master #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_write,
    // AXI-Lite write address
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    // AXI-Lite write data
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    // AXI-Lite write response
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    // AXI-Lite read address
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    // AXI-Lite read data
    input  logic              rvalid,
    output logic              rready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // registered channel controls
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid,  w_wvalid_nxt;
    logic                r_bready,  w_bready_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready,  w_rready_nxt;
    logic                r_aw_done, w_aw_done_nxt;
    logic                r_w_done,  w_w_done_nxt;

    // latched command payload
    logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic [3:0]          r_wstrb, w_wstrb_nxt;
    logic                r_write, w_write_nxt;

    // response registers
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]         r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]          r_rsp_resp,  w_rsp_resp_nxt;
    logic                r_rsp_write, w_rsp_write_nxt;

    // handshake strobes
    logic                w_cmd_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_rsp_hs;
    logic [ADDR_W-1:0]   w_addr_aligned;

    assign cmd_ready = (r_state == S_IDLE);

    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_aw_hs   = r_awvalid && awready;
    assign w_w_hs    = r_wvalid  && wready;
    assign w_b_hs    = bvalid    && r_bready;
    assign w_ar_hs   = r_arvalid && arready;
    assign w_r_hs    = rvalid    && r_rready;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;

    // AXI-Lite is word-addressed here: the two byte-lane bits are always cleared
    assign w_addr_aligned = cmd_addr & ~ADDR_W'(3);

    assign awvalid   = r_awvalid;
    assign awaddr    = r_addr;
    assign awprot    = 3'b000;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign bready    = r_bready;
    assign arvalid   = r_arvalid;
    assign araddr    = r_addr;
    assign arprot    = 3'b000;
    assign rready    = r_rready;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign rsp_write = r_rsp_write;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_write_nxt     = r_write;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_rsp_write_nxt = r_rsp_write;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_addr_nxt  = w_addr_aligned;
                    w_wdata_nxt = cmd_wdata;
                    w_wstrb_nxt = cmd_wstrb;
                    w_write_nxt = cmd_write;
                    if (cmd_write) begin
                        w_state_nxt   = S_WR_REQ;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = S_RD_REQ;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end

            S_WR_REQ: begin
                // AW and W complete independently, in any order
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                end
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done  | w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt   = S_WR_RESP;
                    w_bready_nxt  = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end

            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_rdata_nxt = 32'h0;
                    w_rsp_resp_nxt  = bresp;
                    w_rsp_write_nxt = r_write;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end

            S_RD_REQ: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (w_r_hs) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_rdata_nxt = rdata;
                    w_rsp_resp_nxt  = rresp;
                    w_rsp_write_nxt = r_write;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end

            S_RESP: begin
                // response fields stay frozen until the consumer takes them
                if (w_rsp_hs) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Channel controls, latched command and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'h0;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_resp  <= 2'b00;
            r_rsp_write <= 1'b0;
        end else begin
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_write     <= w_write_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_rsp_write <= w_rsp_write_nxt;
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a RAM-backed AXI-Lite responder with
// configurable ready delays, a reference memory model that predicts every
// response when the command is issued, and a response monitor that pops
// and compares those predictions.
module tb_axil_cmd_master;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;

    axil_cmd_master #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        wr;
    } exp_t;
    exp_t exp_q[$];
    int   issued  = 0;
    int   rsp_cnt = 0;

    // reference memory: word index -> contents (absent words read as zero)
    logic [31:0] model_mem [int];

    function automatic logic [31:0] model_rd(input logic [ADDR_W-1:0] a);
        int k = int'(a) / 4;
        if (model_mem.exists(k)) return model_mem[k];
        return 32'h0;
    endfunction

    // ---------------- responder configuration ----------------
    bit       cfg_rand = 0;
    int       dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    function automatic int pick(input int fixed);
        if (cfg_rand) return int'($urandom_range(0, 3));
        return fixed;
    endfunction

    // observations made by the responder
    int          aw_cyc, w_cyc, ar_cyc;
    int          n_aw = 0, n_w = 0;
    bit          bready_early = 0;
    logic [ADDR_W-1:0] cap_awaddr, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;

    logic [31:0] ram [0:1023];

    // ---------------- AXI-Lite RAM responder ----------------
    initial begin : responder
        bit f_aw, f_w, f_b, f_ar, f_r;
        bit aw_got, w_got, b_pend, ar_got;
        int aw_wait, w_wait, ar_wait, aw_tgt, w_tgt, ar_tgt, b_cnt, r_cnt;
        logic [31:0] m;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
        aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_tgt = 0; w_tgt = 0; ar_tgt = 0;
        b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
                aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                continue;
            end
            // retire handshakes that completed on the edge just passed
            if (f_aw) begin awready = 0; aw_got = 1; aw_wait = 0; end
            if (f_w)  begin wready = 0;  w_got = 1;  w_wait = 0;  end
            if (f_b)  bvalid = 0;
            if (f_ar) begin arready = 0; ar_got = 1; ar_wait = 0; r_cnt = pick(dly_r); end
            if (f_r)  rvalid = 0;
            if (aw_got && w_got) begin
                m = ram[int'(cap_awaddr) / 4];
                for (int b = 0; b < 4; b++)
                    if (cap_wstrb[b]) m[8*b +: 8] = cap_wdata[8*b +: 8];
                ram[int'(cap_awaddr) / 4] = m;
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = pick(dly_b);
            end
            if (b_pend) begin
                if (b_cnt == 0) begin bvalid = 1; bresp = cfg_bresp; b_pend = 0; end
                else b_cnt--;
            end
            if (ar_got) begin
                if (r_cnt == 0) begin
                    rvalid = 1; rdata = ram[int'(cap_araddr) / 4]; rresp = cfg_rresp; ar_got = 0;
                end else r_cnt--;
            end
            if (awvalid && !awready && !aw_got) begin
                if (aw_wait == 0) aw_tgt = pick(dly_aw);
                if (aw_wait >= aw_tgt) awready = 1; else aw_wait++;
            end
            if (wvalid && !wready && !w_got) begin
                if (w_wait == 0) w_tgt = pick(dly_w);
                if (w_wait >= w_tgt) wready = 1; else w_wait++;
            end
            if (arvalid && !arready && !ar_got) begin
                if (ar_wait == 0) ar_tgt = pick(dly_ar);
                if (ar_wait >= ar_tgt) arready = 1; else ar_wait++;
            end
            // handshakes that will complete on the coming edge
            if (bready && (awvalid || wvalid)) bready_early = 1;
            f_aw = awvalid && awready;
            f_w  = wvalid && wready;
            f_b  = bvalid && bready;
            f_ar = arvalid && arready;
            f_r  = rvalid && rready;
            if (f_aw) begin
                cap_awaddr = awaddr; aw_cyc = cyc; n_aw++;
                chk("awaddr_align_prot", (awaddr[1:0] == 2'b00) && (awprot == 3'b000),
                    {awprot, awaddr}, {3'b000, awaddr & ~12'h3});
            end
            if (f_w) begin cap_wdata = wdata; cap_wstrb = wstrb; w_cyc = cyc; n_w++; end
            if (f_ar) begin
                cap_araddr = araddr; ar_cyc = cyc;
                chk("araddr_align_prot", (araddr[1:0] == 2'b00) && (arprot == 3'b000),
                    {arprot, araddr}, {3'b000, araddr & ~12'h3});
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    bit   rsp_rand  = 0;
    int   stall_req = 0;
    int   first_cyc, hs_cyc, stall_len;

    initial begin : monitor
        bit          presenting;
        int          stall;
        logic [34:0] hold, cur, want;
        exp_t        e;
        presenting = 0; stall = 0; rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin presenting = 0; rsp_ready = 0; continue; end
            if (rsp_valid) begin
                cur = {rsp_write, rsp_resp, rsp_rdata};
                if (!presenting) begin
                    presenting = 1; first_cyc = cyc; hold = cur;
                    if (stall_req > 0) begin stall = stall_req; stall_req = 0; end
                    else stall = rsp_rand ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    chk("rsp_hold_stable", (cur == hold) && !cmd_ready,
                        {28'h0, cmd_ready, cur}, {28'h0, 1'b0, hold});
                end
                if (stall > 0) begin
                    rsp_ready = 0; stall--;
                end else begin
                    rsp_ready = 1;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 1'b0, {29'h0, cur}, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        want = {e.wr, e.resp, e.rdata};
                        chk("rsp_fields{write,resp,rdata}", cur == want, {29'h0, cur}, {29'h0, want});
                    end
                    presenting = 0; hs_cyc = cyc; stall_len = cyc - first_cyc; rsp_cnt++;
                end
            end else begin
                rsp_ready = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit upd, output int acc);
        exp_t e;
        logic [31:0] m;
        bit ok;
        e.wr = wr;
        if (wr) begin
            e.rdata = 32'h0; e.resp = cfg_bresp;
            if (upd) begin
                m = model_rd(a);
                for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
                model_mem[int'(a) / 4] = m;
            end
        end else begin
            e.rdata = model_rd(a); e.resp = cfg_rresp;
        end
        exp_q.push_back(e);
        issued++;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        ok = 0; acc = -1;
        for (int k = 0; k < 300; k++) begin
            if (cmd_ready) begin ok = 1; acc = cyc; break; end
            @(negedge clk);
        end
        if (!ok) chk("cmd_accept_timeout", 1'b0, 64'h0, 64'h1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (rsp_cnt == issued && exp_q.size() == 0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("rsp_timeout", 1'b0, 64'(rsp_cnt), 64'(issued));
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc2, hs_a, len_a;
        bit ok;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        repeat (3) @(negedge clk);
        chk("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid} == 6'b0,
            {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 64'h0);
        chk("reset_rsp_fields", {rsp_write, rsp_resp, rsp_rdata} == 35'h0,
            {rsp_write, rsp_resp, rsp_rdata}, 64'h0);
        rst = 0;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready == 1'b1, cmd_ready, 1);

        // zero-wait write latency
        n_aw = 0; n_w = 0;
        issue(1, 12'h000, 32'hCA55E77E, 4'hF, 1, acc);
        wait_done();
        chk("wr_aw_cycle", aw_cyc == acc + 1, aw_cyc - acc, 1);
        chk("wr_w_cycle", w_cyc == acc + 1, w_cyc - acc, 1);
        chk("wr_awaddr", cap_awaddr == 12'h000, cap_awaddr, 0);
        chk("wr_wstrb_wdata", {cap_wstrb, cap_wdata} == {4'hF, 32'hCA55E77E},
            {cap_wstrb, cap_wdata}, {4'hF, 32'hCA55E77E});
        chk("wr_rsp_cycle", first_cyc == acc + 3, first_cyc - acc, 3);

        // write then read back, plus an unaligned read address
        issue(1, 12'h004, 32'hDEADBEEF, 4'hF, 1, acc);
        wait_done();
        issue(0, 12'h004, 32'h0, 4'h0, 1, acc);
        wait_done();
        chk("rd_araddr", cap_araddr == 12'h004, cap_araddr, 12'h004);
        chk("rd_ar_cycle", ar_cyc == acc + 1, ar_cyc - acc, 1);
        chk("rd_rsp_cycle", first_cyc == acc + 3, first_cyc - acc, 3);
        issue(0, 12'h007, 32'h0, 4'h0, 1, acc);
        wait_done();
        chk("rd_unaligned_araddr", cap_araddr == 12'h004, cap_araddr, 12'h004);

        // AW/W ordering: aw first by 3, w first by 3, simultaneous
        for (int m = 0; m < 3; m++) begin
            int want;
            dly_aw = (m == 1) ? 3 : 0;
            dly_w  = (m == 0) ? 3 : 0;
            want   = (m == 0) ? 3 : ((m == 1) ? -3 : 0);
            n_aw = 0; n_w = 0; bready_early = 0;
            issue(1, 12'(16 + 4 * m), $urandom, 4'hF, 1, acc);
            wait_done();
            repeat (3) @(negedge clk);
            chk("order_single_aw_w", (n_aw == 1) && (n_w == 1), {n_aw[31:0], n_w[31:0]}, {32'd1, 32'd1});
            chk("order_w_minus_aw", (w_cyc - aw_cyc) == want, 64'(w_cyc - aw_cyc), 64'(want));
            chk("order_bready_after_both", !bready_early, bready_early, 0);
            chk("order_single_rsp", rsp_cnt == issued, rsp_cnt, issued);
        end
        dly_aw = 0; dly_w = 0;

        // response backpressure with a queued command behind it
        stall_req = 5;
        issue(0, 12'h000, 32'h0, 4'h0, 1, acc);
        issue(0, 12'h004, 32'h0, 4'h0, 1, acc2);
        hs_a = hs_cyc; len_a = stall_len;
        wait_done();
        chk("bp_stall_length", len_a == 5, len_a, 5);
        chk("bp_next_accept", acc2 == hs_a + 1, acc2 - hs_a, 1);

        // error responses pass through
        cfg_bresp = 2'b10;
        issue(1, 12'h020, 32'h12345678, 4'h3, 1, acc);
        wait_done();
        cfg_bresp = 2'b00; cfg_rresp = 2'b11;
        issue(0, 12'h020, 32'h0, 4'h0, 1, acc);
        wait_done();
        cfg_rresp = 2'b00;

        // reset in the middle of a write request
        dly_aw = 10; dly_w = 10;
        issue(1, 12'h008, 32'hBAADF00D, 4'hF, 0, acc);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (awvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_test_awvalid_seen", ok, ok, 1);
        rst = 1;
        #1;
        chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid} == 6'b0,
            {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 64'h0);
        chk("rst_mid_cmd_ready", cmd_ready == 1'b1, cmd_ready, 1);
        exp_q.delete();
        issued = rsp_cnt;
        repeat (2) @(negedge clk);
        rst = 0;
        dly_aw = 0; dly_w = 0;
        issue(0, 12'h008, 32'h0, 4'h0, 1, acc);
        wait_done();
        chk("rst_then_read_araddr", cap_araddr == 12'h008, cap_araddr, 12'h008);

        // randomized read-modify-write traffic
        cfg_rand = 1; rsp_rand = 1;
        for (int i = 0; i < 1024; i++) begin
            logic [ADDR_W-1:0] a;
            a = 12'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            issue(0, a, 32'h0, 4'h0, 1, acc);
            issue(1, a, $urandom, 4'($urandom_range(0, 15)), 1, acc);
        end
        for (int i = 0; i < 32; i++) issue(0, 12'(4 * i), 32'h0, 4'h0, 1, acc);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
